// File: rtl/pm_loader.sv
// Boot loader: fills the 32x8 program memory from a length-prefixed, checksummed
// byte stream, pads unused locations with NOP and then releases the CPU reset.
module pm_loader #(
  parameter int PM_DEPTH = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8
) (
  input  logic              clk_ldr,
  input  logic              rst_ldr,
  input  logic              start_ldr,
  input  logic [ADDR_W:0]   len_ldr,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [DATA_W-1:0] pm_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(PM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_FILL,
    S_RUN,
    S_ERR
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    len_q;
  logic [DATA_W-1:0]   sum;
  logic                xfer;
  logic                len_ok;
  logic                start_ok;

  // byte_ready is registered from the next state, so it already reflects LOAD/CHECK.
  assign xfer     = byte_valid && byte_ready;
  assign len_ok   = (len_ldr != '0) && (len_ldr <= DEPTH_C);
  assign start_ok = start_ldr && len_ok;

  always_comb begin
    // NOTE: default assigned first so every path drives state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: begin
        if (start_ldr) state_nx = len_ok ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
        if (xfer && (cnt + CNT_W'(1) == len_q)) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (xfer) begin
          if (byte_data != sum)     state_nx = S_ERR;
          else if (len_q < DEPTH_C) state_nx = S_FILL;
          else                      state_nx = S_RUN;
        end
      end
      S_FILL: begin
        if (cnt == LAST_C) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_ldr) begin
    if (rst_ldr) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      sum        <= '0;
      byte_ready <= 1'b0;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_ready <= (state_nx == S_LOAD) || (state_nx == S_CHECK);
      busy       <= (state_nx == S_LOAD) || (state_nx == S_CHECK) || (state_nx == S_FILL);
      done       <= (state_nx == S_RUN);
      err        <= (state_nx == S_ERR);
      // Release only once RUN has been held a full cycle, after the final write.
      cpu_rst    <= !((state == S_RUN) && (state_nx == S_RUN));
      pm_we      <= 1'b0;

      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start_ok) begin
            len_q <= len_ldr;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            pm_we    <= 1'b1;
            pm_addr  <= cnt[ADDR_W-1:0];
            pm_wdata <= byte_data;
            sum      <= sum + byte_data;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        S_FILL: begin
          pm_we    <= 1'b1;
          pm_addr  <= cnt[ADDR_W-1:0];
          pm_wdata <= '0;
          cnt      <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: a write scoreboard plus a program-memory image
// model derived from the session rules, with literal timing checks per session.
module tb_pm_loader;

  logic       clk_ldr = 1'b0;
  logic       rst_ldr = 1'b1;
  logic       start_ldr = 1'b0;
  logic [5:0] len_ldr = '0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready, pm_we, cpu_rst, busy, done, err;
  logic [4:0] pm_addr;
  logic [7:0] pm_wdata;

  pm_loader dut (
    .clk_ldr    (clk_ldr),
    .rst_ldr    (rst_ldr),
    .start_ldr  (start_ldr),
    .len_ldr    (len_ldr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk_ldr = ~clk_ldr;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         n_we = 0;
  int         last_we_cyc = 0;
  wr_t        exp_q[$];
  logic [7:0] pmem[32];
  logic [7:0] model_mem[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_ldr) cyc <= cyc + 1;

  // Program memory the loader is writing into.
  always @(posedge clk_ldr) if (pm_we === 1'b1) pmem[pm_addr] <= pm_wdata;

  // Compare process: every write strobe must match the next expected write in order.
  always @(negedge clk_ldr) begin
    if (pm_we === 1'b1) begin
      wr_t e;
      n_we++;
      last_we_cyc = cyc;
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(pm_addr), 32'(e.addr));
        check("wr_data", 32'(pm_wdata), 32'(e.data));
      end
    end
  end

  function automatic logic [7:0] model_sum(input logic [7:0] d[$]);
    int s = 0;
    foreach (d[i]) s += int'(d[i]);
    return 8'(s % 256);
  endfunction

  // Expected effect of a session with a valid length: data at 0..L-1, then NOP fill
  // up to the top only if the checksum matches and memory is not already full.
  task automatic expect_session(input int len, input logic [7:0] d[$], input logic [7:0] chk);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back('{addr: 5'(i), data: d[i]});
      model_mem[i] = d[i];
    end
    if (chk == model_sum(d)) begin
      for (int a = len; a < 32; a++) begin
        exp_q.push_back('{addr: 5'(a), data: 8'h00});
        model_mem[a] = 8'h00;
      end
    end
  endtask

  task automatic start_session(input logic [5:0] len);
    start_ldr = 1'b1;
    len_ldr   = len;
    @(posedge clk_ldr);
    #1;
    start_ldr = 1'b0;
    t0   = cyc;
    n_we = 0;
  endtask

  function automatic int cur_cycle();
    return cyc - t0 + 1;
  endfunction

  task automatic wait_cycle(input int n);
    while (cur_cycle() < n) begin
      @(posedge clk_ldr);
      #1;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!byte_ready && k < 200) begin
      @(posedge clk_ldr);
      #1;
      k++;
    end
    check("byte_ready_wait", 32'(byte_ready), 1);
  endtask

  // Sends bytes with `gap` idle cycles before each; a start pulse is injected in
  // the gap before byte `glitch_at` (-1 for none).
  task automatic send_stream(input logic [7:0] d[$], input int gap, input int glitch_at);
    foreach (d[i]) begin
      for (int g = 0; g < gap; g++) begin
        byte_valid = 1'b0;
        if (i == glitch_at) begin
          start_ldr = 1'b1;
          len_ldr   = 6'd5;
        end
        @(posedge clk_ldr);
        #1;
        start_ldr = 1'b0;
      end
      byte_valid = 1'b1;
      byte_data  = d[i];
      wait_ready();
      @(posedge clk_ldr);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_one(input logic [7:0] b, input int gap);
    logic [7:0] q[$];
    q.push_back(b);
    send_stream(q, gap, -1);
  endtask

  task automatic end_session(input string tag, input int exp_n);
    int mism = 0;
    repeat (3) @(posedge clk_ldr);
    #1;
    check({tag, "_n_we"}, 32'(n_we), 32'(exp_n));
    check({tag, "_exp_drained"}, 32'(exp_q.size()), 0);
    for (int a = 0; a < 32; a++) if (pmem[a] !== model_mem[a]) mism++;
    check({tag, "_mem_image"}, 32'(mism), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] s3[$];
    logic [7:0] s2[$];
    logic [7:0] s1[$];
    logic [7:0] s32[$];

    for (int a = 0; a < 32; a++) begin
      pmem[a]      = 8'hAA;
      model_mem[a] = 8'hAA;
    end
    s3.push_back(8'h51); s3.push_back(8'hE1); s3.push_back(8'hF2);
    s2.push_back(8'h11); s2.push_back(8'h22);
    s1.push_back(8'h00);
    for (int i = 0; i < 32; i++) s32.push_back(8'(i * 7 + 3));

    // Pin the checksum model against hand-computed sums.
    check("model_sum_len3", 32'(model_sum(s3)), 32'h24);
    check("model_sum_len32", 32'(model_sum(s32)), 32'hF0);

    // Reset values.
    repeat (3) @(posedge clk_ldr);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 0);
    check("rst_pm_we", 32'(pm_we), 0);
    check("rst_pm_addr", 32'(pm_addr), 0);
    check("rst_pm_wdata", 32'(pm_wdata), 0);
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rst_ldr = 1'b0;
    @(posedge clk_ldr);
    #1;

    // Reset in the middle of LOAD after two bytes.
    exp_q.push_back('{addr: 5'd0, data: 8'h11});
    exp_q.push_back('{addr: 5'd1, data: 8'h22});
    model_mem[0] = 8'h11;
    model_mem[1] = 8'h22;
    start_session(6'd4);
    send_stream(s2, 0, -1);
    rst_ldr = 1'b1;
    @(posedge clk_ldr);
    #1;
    check("midrst_pm_we", 32'(pm_we), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_byte_ready", 32'(byte_ready), 0);
    check("midrst_cpu_rst", 32'(cpu_rst), 1);
    rst_ldr = 1'b0;
    end_session("midrst", 2);

    // Zero length from IDLE.
    start_session(6'd0);
    check("len0_err", 32'(err), 1);
    check("len0_busy", 32'(busy), 0);
    check("len0_cpu_rst", 32'(cpu_rst), 1);
    end_session("len0", 0);

    // Good length-3 session at full rate, started from ERR.
    expect_session(3, s3, 8'h24);
    start_session(6'd3);
    check("t3_ready_c1", 32'(byte_ready), 1);
    check("t3_err_clear_c1", 32'(err), 0);
    send_stream(s3, 0, -1);
    send_one(8'h24, 0);
    check("t3_cycle_after_check", 32'(cur_cycle()), 5);
    check("t3_fill_ready", 32'(byte_ready), 0);
    wait_cycle(33);
    check("t3_c33_busy", 32'(busy), 1);
    check("t3_c33_done", 32'(done), 0);
    wait_cycle(34);
    check("t3_c34_done", 32'(done), 1);
    check("t3_c34_busy", 32'(busy), 0);
    check("t3_c34_cpu_rst", 32'(cpu_rst), 1);
    wait_cycle(35);
    check("t3_c35_cpu_rst", 32'(cpu_rst), 0);
    check("t3_last_we_cycle", 32'(last_we_cyc - t0 + 1), 34);
    end_session("t3", 32);

    // Length 33 from RUN.
    start_session(6'd33);
    check("len33_err", 32'(err), 1);
    check("len33_done", 32'(done), 0);
    check("len33_cpu_rst", 32'(cpu_rst), 1);
    end_session("len33", 0);

    // Bad checksum: data is written, no fill, stays in error with CPU held.
    expect_session(3, s3, 8'h25);
    start_session(6'd3);
    check("bad_err_clear_c1", 32'(err), 0);
    send_stream(s3, 0, -1);
    check("bad_c4_busy", 32'(busy), 1);
    send_one(8'h25, 0);
    check("bad_c5_err", 32'(err), 1);
    check("bad_c5_busy", 32'(busy), 0);
    check("bad_c5_done", 32'(done), 0);
    check("bad_c5_cpu_rst", 32'(cpu_rst), 1);
    end_session("bad", 3);

    // Full memory with a throttled stream and an ignored start pulse during LOAD.
    expect_session(32, s32, 8'hF0);
    start_session(6'd32);
    send_stream(s32, 1, 10);
    check("l32_busy_in_check", 32'(busy), 1);
    send_one(8'hF0, 1);
    check("l32_run_done", 32'(done), 1);
    check("l32_run_busy", 32'(busy), 0);
    check("l32_run_cpu_rst", 32'(cpu_rst), 1);
    @(posedge clk_ldr);
    #1;
    check("l32_release", 32'(cpu_rst), 0);
    end_session("l32", 32);

    // Restart from RUN with a single NOP byte.
    check("t6_pre_cpu_rst", 32'(cpu_rst), 0);
    expect_session(1, s1, 8'h00);
    start_session(6'd1);
    check("t6_c1_cpu_rst", 32'(cpu_rst), 1);
    check("t6_c1_done", 32'(done), 0);
    check("t6_c1_busy", 32'(busy), 1);
    send_stream(s1, 0, -1);
    send_one(8'h00, 0);
    wait_cycle(34);
    check("t6_c34_done", 32'(done), 1);
    check("t6_c34_cpu_rst", 32'(cpu_rst), 1);
    wait_cycle(35);
    check("t6_c35_cpu_rst", 32'(cpu_rst), 0);
    check("t6_last_we_cycle", 32'(last_we_cyc - t0 + 1), 34);
    end_session("t6", 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
